control_unit: RTL

CONTROL_UNIT -- requirements
Module: control_unit

---
 rtl/control_unit_pkg.sv | 29 ++
 rtl/control_unit.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/control_unit_pkg.sv
// Shared channel definitions: control-unit state encodings, status bits and
// the command bit that selects write versus read direction.
package control_unit_pkg;

  typedef enum logic [3:0] {
    ST_IDLE         = 4'd0,
    ST_PROPAGATE    = 4'd1,
    ST_ADDRESS_IN   = 4'd2,
    ST_COMMAND_WAIT = 4'd3,
    ST_INIT_STATUS  = 4'd4,
    ST_INIT_ACCEPT  = 4'd5,
    ST_DATA         = 4'd6,
    ST_DATA_WAIT    = 4'd7,
    ST_END_STATUS   = 4'd8,
    ST_DISCONNECT   = 4'd9
  } cu_state_t;

  localparam logic [7:0] STATUS_CE  = 8'h10;
  localparam logic [7:0] STATUS_DE  = 8'h20;
  localparam logic [7:0] STATUS_END = STATUS_CE | STATUS_DE;

  // Command bit 0 set means a write/control command (channel -> device).
  localparam int CMD_WRITE_BIT = 0;

  function automatic logic cmd_is_write(input logic [7:0] cmd);
    return cmd[CMD_WRITE_BIT];
  endfunction

endpackage

// File: rtl/control_unit.sv
// Channel control unit: selection, address echo, command latch, initial
// status, byte transfer with stop handling and ending status.
module control_unit
  import control_unit_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] a_bus_out,
  input  logic       a_operational_out,
  input  logic       a_select_out,
  input  logic       a_address_out,
  input  logic       a_command_out,
  input  logic       a_service_out,
  output logic [7:0] a_bus_in,
  output logic       a_operational_in,
  output logic       a_select_in,
  output logic       a_address_in,
  output logic       a_status_in,
  output logic       a_service_in,
  input  logic [7:0] cu_address,
  input  logic [7:0] dev_status,
  input  logic [7:0] xfer_length,
  input  logic [7:0] tx_data,
  output logic       tx_strobe,
  output logic [7:0] rx_data,
  output logic       rx_strobe,
  output logic [7:0] command,
  output logic       command_strobe,
  output logic       active
);

  cu_state_t  state_q;
  logic [7:0] bus_in_q;
  logic       operational_in_q;
  logic       select_in_q;
  logic       address_in_q;
  logic       status_in_q;
  logic       service_in_q;
  logic       tx_strobe_q;
  logic [7:0] rx_data_q;
  logic       rx_strobe_q;
  logic [7:0] command_q;
  logic       command_strobe_q;
  logic [7:0] remaining_q;
  logic       stop_q;

  logic       addr_match_d;
  logic       is_write_d;
  logic [7:0] data_byte_d;
  logic [7:0] remaining_d;

  assign addr_match_d = (a_bus_out == cu_address);
  assign is_write_d   = cmd_is_write(command_q);
  assign data_byte_d  = is_write_d ? 8'h00 : tx_data;
  // Saturating decrement: the count never wraps below zero.
  assign remaining_d  = (remaining_q == 8'd0) ? 8'd0 : (remaining_q - 8'd1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q          <= ST_IDLE;
      bus_in_q         <= 8'h00;
      operational_in_q <= 1'b0;
      select_in_q      <= 1'b0;
      address_in_q     <= 1'b0;
      status_in_q      <= 1'b0;
      service_in_q     <= 1'b0;
      tx_strobe_q      <= 1'b0;
      rx_data_q        <= 8'h00;
      rx_strobe_q      <= 1'b0;
      command_q        <= 8'h00;
      command_strobe_q <= 1'b0;
      remaining_q      <= 8'h00;
      stop_q           <= 1'b0;
    end else begin
      tx_strobe_q      <= 1'b0;
      rx_strobe_q      <= 1'b0;
      command_strobe_q <= 1'b0;

      if (!a_operational_out) begin
        // Channel system reset wins over every transition.
        state_q          <= ST_IDLE;
        bus_in_q         <= 8'h00;
        operational_in_q <= 1'b0;
        select_in_q      <= 1'b0;
        address_in_q     <= 1'b0;
        status_in_q      <= 1'b0;
        service_in_q     <= 1'b0;
        stop_q           <= 1'b0;
      end else begin
        unique case (state_q)
          ST_IDLE: begin
            if (a_select_out && a_address_out && addr_match_d) begin
              operational_in_q <= 1'b1;
              state_q          <= ST_ADDRESS_IN;
            end else if (a_select_out) begin
              select_in_q <= 1'b1;
              state_q     <= ST_PROPAGATE;
            end
          end

          ST_PROPAGATE: begin
            select_in_q <= a_select_out;
            if (!a_select_out) begin
              state_q <= ST_IDLE;
            end
          end

          ST_ADDRESS_IN: begin
            if (a_command_out) begin
              command_q        <= a_bus_out;
              command_strobe_q <= 1'b1;
              remaining_q      <= xfer_length;
              stop_q           <= 1'b0;
              address_in_q     <= 1'b0;
              bus_in_q         <= 8'h00;
              state_q          <= ST_COMMAND_WAIT;
            end else if (!a_address_out) begin
              address_in_q <= 1'b1;
              bus_in_q     <= cu_address;
            end
          end

          ST_COMMAND_WAIT: begin
            if (!a_command_out) begin
              status_in_q <= 1'b1;
              bus_in_q    <= dev_status;
              state_q     <= ST_INIT_STATUS;
            end
          end

          ST_INIT_STATUS: begin
            if (a_service_out) begin
              status_in_q <= 1'b0;
              bus_in_q    <= 8'h00;
              state_q     <= ST_INIT_ACCEPT;
            end
          end

          ST_INIT_ACCEPT: begin
            if (!a_service_out) begin
              if (dev_status == 8'h00 && command_q != 8'h00) begin
                // A zero-length transfer skips straight to ending status.
                if (remaining_q == 8'd0) begin
                  status_in_q <= 1'b1;
                  bus_in_q    <= STATUS_END;
                  state_q     <= ST_END_STATUS;
                end else begin
                  service_in_q <= 1'b1;
                  bus_in_q     <= data_byte_d;
                  state_q      <= ST_DATA;
                end
              end else begin
                operational_in_q <= 1'b0;
                state_q          <= ST_IDLE;
              end
            end
          end

          ST_DATA: begin
            if (a_service_out) begin
              service_in_q <= 1'b0;
              bus_in_q     <= 8'h00;
              remaining_q  <= remaining_d;
              if (is_write_d) begin
                rx_data_q   <= a_bus_out;
                rx_strobe_q <= 1'b1;
              end else begin
                tx_strobe_q <= 1'b1;
              end
              state_q <= ST_DATA_WAIT;
            end else if (a_command_out) begin
              service_in_q <= 1'b0;
              bus_in_q     <= 8'h00;
              stop_q       <= 1'b1;
              state_q      <= ST_DATA_WAIT;
            end else begin
              bus_in_q <= data_byte_d;
            end
          end

          ST_DATA_WAIT: begin
            if (!a_service_out && !a_command_out) begin
              if (stop_q || remaining_q == 8'd0) begin
                status_in_q <= 1'b1;
                bus_in_q    <= STATUS_END;
                state_q     <= ST_END_STATUS;
              end else begin
                service_in_q <= 1'b1;
                bus_in_q     <= data_byte_d;
                state_q      <= ST_DATA;
              end
            end
          end

          ST_END_STATUS: begin
            if (a_service_out) begin
              status_in_q      <= 1'b0;
              operational_in_q <= 1'b0;
              bus_in_q         <= 8'h00;
              state_q          <= ST_DISCONNECT;
            end
          end

          ST_DISCONNECT: begin
            if (!a_service_out) begin
              stop_q  <= 1'b0;
              state_q <= ST_IDLE;
            end
          end

          default: begin
            state_q <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign a_bus_in         = bus_in_q;
  assign a_operational_in = operational_in_q;
  assign a_select_in      = select_in_q;
  assign a_address_in     = address_in_q;
  assign a_status_in      = status_in_q;
  assign a_service_in     = service_in_q;
  assign tx_strobe        = tx_strobe_q;
  assign rx_data          = rx_data_q;
  assign rx_strobe        = rx_strobe_q;
  assign command          = command_q;
  assign command_strobe   = command_strobe_q;
  assign active           = (state_q != ST_IDLE);

endmodule
